// File: rtl/morse_player_pkg.sv
// Shared types and constants for the Morse pattern player.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GAP_NONE   = 2'd0,
        GAP_LETTER = 2'd1,
        GAP_WORD   = 2'd2,
        GAP_RSVD   = 2'd3
    } gap_e;

    localparam int unsigned LETTER_GAP_UNITS = 3;
    localparam int unsigned WORD_GAP_UNITS   = 7;

    // Trailing silence in units for a gap code; the reserved code plays no gap.
    function automatic logic [2:0] gap_units(input logic [1:0] code);
        logic [2:0] units;
        units = 3'd0;
        case (code)
            GAP_LETTER: units = 3'(LETTER_GAP_UNITS);
            GAP_WORD:   units = 3'(WORD_GAP_UNITS);
            default:    units = 3'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/morse_player_if.sv
// Request/status bundle between a character sequencer (master) and the player (slave).
interface morse_player_if #(
    parameter int PATTERN_W = 20,
    parameter int LEN_W     = $clog2(PATTERN_W + 1)
);
    // Handshake: a request transfers on the rising clock edge where i_valid and
    // o_ready are both high; o_ready is high only while the player is idle, and
    // request fields are sampled only on that edge. The master may hold i_valid
    // at any time; while the player is busy it is simply ignored.
    logic [PATTERN_W-1:0] i_pattern;
    logic [LEN_W-1:0]     i_len;
    logic [1:0]           i_gap;
    logic                 i_valid;
    logic                 o_ready;
    logic                 o_led;
    logic                 o_busy;
    logic                 o_unit_tick;
    logic                 o_done;
    logic [1:0]           dbg_state;

    modport master (
        output i_pattern, i_len, i_gap, i_valid,
        input  o_ready, o_led, o_busy, o_unit_tick, o_done, dbg_state
    );

    modport slave (
        input  i_pattern, i_len, i_gap, i_valid,
        output o_ready, o_led, o_busy, o_unit_tick, o_done, dbg_state
    );

endinterface

// File: rtl/morse_player_unit_tick_gen.sv
// Modulo-TICK_DIV unit timer: tick is high during the last cycle of each unit.
module unit_tick_gen #(
    parameter int unsigned TICK_DIV = 3000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/morse_player.sv
// Plays a variable-length MSB-first on/off unit pattern on one LED, then an optional gap.
module morse_player
    import morse_pkg::*;
#(
    parameter int PATTERN_W = 20,
    parameter int TICK_DIV  = 3000000,
    parameter int LEN_W     = $clog2(PATTERN_W + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    morse_player_if.slave  bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_PLAY = PLAY;
    localparam logic [1:0] S_GAP  = GAP;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PATTERN_W);

    logic [1:0]           state;
    logic [PATTERN_W-1:0] shift_q;
    logic [PATTERN_W-1:0] shift_next;
    logic [LEN_W-1:0]     units_left;
    logic [2:0]           gap_left;
    logic                 led_q;
    logic                 done_q;
    logic                 tick;
    logic                 idle;
    logic                 busy;
    logic                 accept;
    logic [LEN_W-1:0]     len_clamped;
    logic [2:0]           gap_req;

    assign idle        = (state == S_IDLE);
    assign busy        = !idle;
    assign accept      = bus.i_valid && idle;
    assign len_clamped = (bus.i_len > MAX_LEN) ? MAX_LEN : bus.i_len;
    assign gap_req     = gap_units(bus.i_gap);
    assign shift_next  = shift_q << 1;

    // Counter is held clear while idle so every request starts unit-aligned.
    unit_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (i_clk),
        .rst  (i_rst),
        .clr  (idle),
        .en   (busy),
        .tick (tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            shift_q    <= '0;
            units_left <= '0;
            gap_left   <= 3'd0;
            led_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    led_q <= 1'b0;
                    if (accept) begin
                        shift_q    <= bus.i_pattern;
                        units_left <= len_clamped;
                        gap_left   <= gap_req;
                        if (len_clamped != '0) begin
                            state <= S_PLAY;
                            led_q <= bus.i_pattern[PATTERN_W-1];
                        end else if (gap_req != 3'd0) begin
                            state <= S_GAP;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end

                S_PLAY: begin
                    if (tick) begin
                        shift_q    <= shift_next;
                        units_left <= units_left - LEN_W'(1);
                        // Last unit: pattern bits below the length are never shown.
                        if (units_left == LEN_W'(1)) begin
                            led_q <= 1'b0;
                            if (gap_left != 3'd0) begin
                                state <= S_GAP;
                            end else begin
                                state  <= S_IDLE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            led_q <= shift_next[PATTERN_W-1];
                        end
                    end
                end

                S_GAP: begin
                    led_q <= 1'b0;
                    if (tick) begin
                        gap_left <= gap_left - 3'd1;
                        if (gap_left == 3'd1) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    led_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready     = idle;
    assign bus.o_busy      = busy;
    assign bus.o_led       = led_q;
    assign bus.o_unit_tick = tick;
    assign bus.o_done      = done_q;
    assign bus.dbg_state   = state;

endmodule
